fsm_sar: RTL and testbench

Successive-approximation register (SAR) controller for a `Width`-bit SAR ADC. On a start request it asserts a one-cycle sample command to the track/hold stage. It then performs a binary search MSB-first, driving the trial code to the capacitive/resistive DAC and reading back the analog comparator. It sits between the sequencing logic, which issues `start_i` and consumes `result_o`/`eoc_o`, and the analog front end, which consumes `sample_o`/`dac_o` and provides `cmp_i`.

---
 rtl/fsm_sar.sv | 114 +++++++++++
 tb/tb_fsm_sar.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_sar.sv
// fsm_sar: successive-approximation register controller for a Width-bit SAR ADC.
// Issues a one-cycle track/hold sample command, then resolves the code MSB-first
// by driving trial codes to the DAC and reading back the comparator.
//
// Handshake: start_i is a level request that is only looked at while the FSM is
// IDLE; there is no ready/ack. A request seen at edge E0 produces sample_o in
// cycle E0+1, CONVERT in cycles E0+2..E0+Width+1, and a one-cycle eoc_o at
// E0+Width+2. At that point result_o carries the new code. Requests made while
// a conversion is in progress are dropped, not queued.
module fsm_sar #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cmp_i,
    output logic [Width-1:0] result_o,
    output logic [Width-1:0] dac_o,
    output logic             sample_o,
    output logic             eoc_o,
    output logic [1:0]       state_o
);

    localparam int IW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [Width-1:0] MSB_ONLY = {1'b1, {(Width-1){1'b0}}};
    localparam logic [IW-1:0]    IDX_TOP  = IW'(Width - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_m1;
    logic [Width-1:0] trial_q;
    logic [Width-1:0] trial_d;
    logic [Width-1:0] result_q;
    logic [Width-1:0] dac_q;
    logic             sample_q;
    logic             eoc_q;

    assign idx_m1 = idx_q - IW'(1);

    // Resolve the current trial bit from the comparator and arm the next lower bit.
    always_comb begin
        trial_d = trial_q;
        trial_d[idx_q] = cmp_i;
        if (idx_q != '0) begin
            trial_d[idx_m1] = 1'b1;
        end
    end

    // Conversion sequencer with registered outputs so the analog side sees clean levels.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            dac_q    <= '0;
            sample_q <= 1'b0;
            eoc_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    eoc_q <= 1'b0;
                    dac_q <= '0;
                    if (start_i) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                    end else begin
                        sample_q <= 1'b0;
                    end
                end
                SAMPLE: begin
                    sample_q <= 1'b0;
                    trial_q  <= MSB_ONLY;
                    dac_q    <= MSB_ONLY;
                    idx_q    <= IDX_TOP;
                    state_q  <= CONVERT;
                end
                CONVERT: begin
                    trial_q <= trial_d;
                    dac_q   <= trial_d;
                    if (idx_q == '0) begin
                        result_q <= trial_d;
                        eoc_q    <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q <= idx_m1;
                    end
                end
                DONE: begin
                    eoc_q   <= 1'b0;
                    dac_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign dac_o    = dac_q;
    assign sample_o = sample_q;
    assign eoc_o    = eoc_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_fsm_sar.sv
// Bench for fsm_sar at Width=10. A reference model derives the expected DAC
// trial sequence and final code from the comparator bit pattern with plain
// arithmetic; directed and randomized conversions are checked cycle by cycle.
module tb_fsm_sar;

    localparam int W = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic         cmp;
    logic [W-1:0] result;
    logic [W-1:0] dac;
    logic         sample;
    logic         eoc;
    logic [1:0]   state;

    int checks;
    int failures;

    logic [W-1:0] exp_q[$];

    fsm_sar #(.Width(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .cmp_i    (cmp),
        .result_o (result),
        .dac_o    (dac),
        .sample_o (sample),
        .eoc_o    (eoc),
        .state_o  (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: if the comparator answers follow the bits of code
    // (MSB first), step k tries the already decided upper bits plus a 1 at
    // position W-1-k, and the final result is code itself.
    task automatic model_load(input logic [W-1:0] code);
        int p;
        int v;
        exp_q.delete();
        for (int k = 0; k < W; k++) begin
            p = W - 1 - k;
            v = ((int'(code) >> (p + 1)) << (p + 1)) + (1 << p);
            exp_q.push_back(W'(v));
        end
    endtask

    // Driver: called in an IDLE cycle (1 ns after an edge). busy pulses start
    // during CONVERT/DONE; hold keeps start high for back-to-back runs.
    task automatic run_conv(input string name, input logic [W-1:0] code,
                            input bit busy, input bit hold);
        logic [W-1:0] e;
        model_load(code);
        start = 1'b1;
        tick();
        chk({name, ".sample"}, 32'(sample), 32'd1);
        chk({name, ".dac_smp"}, 32'(dac), 32'd0);
        start = hold;
        tick();
        for (int k = 0; k < W; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s.dac%0d", name, k), 32'(dac), 32'(e));
            if (sample !== 1'b0 || eoc !== 1'b0)
                chk($sformatf("%s.strobe%0d", name, k), {30'd0, sample, eoc}, 32'd0);
            cmp = code[W-1-k];
            if (busy) start = 1'(($urandom_range(0, 1)));
            if (hold) start = 1'b1;
            tick();
        end
        chk({name, ".eoc"}, 32'(eoc), 32'd1);
        chk({name, ".result"}, 32'(result), 32'(code));
        chk({name, ".dac_done"}, 32'(dac), 32'(code));
        start = busy | hold;
        cmp = 1'(($urandom_range(0, 1)));
        tick();
        chk({name, ".idle_eoc"}, 32'(eoc), 32'd0);
        chk({name, ".idle_smp"}, 32'(sample), 32'd0);
        chk({name, ".idle_dac"}, 32'(dac), 32'd0);
        chk({name, ".idle_res"}, 32'(result), 32'(code));
        start = hold;
    endtask

    // Idle cycles with a wiggling comparator: nothing may move.
    task automatic idle_cycles(input string name, input int n, input logic [W-1:0] held);
        for (int i = 0; i < n; i++) begin
            cmp = 1'(($urandom_range(0, 1)));
            tick();
            chk({name, ".smp"}, 32'(sample), 32'd0);
            chk({name, ".eoc"}, 32'(eoc), 32'd0);
            chk({name, ".dac"}, 32'(dac), 32'd0);
            chk({name, ".res"}, 32'(result), 32'(held));
        end
    endtask

    logic [W-1:0] rc;
    logic [W-1:0] prev;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        cmp      = 1'b0;
        #12;
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.dac", 32'(dac), 32'd0);
        chk("rst.sample", 32'(sample), 32'd0);
        chk("rst.eoc", 32'(eoc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // directed patterns
        run_conv("alt", 10'h155, 1'b0, 1'b0);
        idle_cycles("hold", 4, 10'h155);
        run_conv("ones", 10'h3FF, 1'b0, 1'b0);
        idle_cycles("gap1", 1, 10'h3FF);
        run_conv("zeros", 10'h000, 1'b0, 1'b0);
        idle_cycles("gap2", 1, 10'h000);

        // start pulsed while busy: exactly one eoc, then quiet idle
        run_conv("busy", 10'h2A7, 1'b1, 1'b0);
        idle_cycles("busy_after", 3, 10'h2A7);

        // start held high: back-to-back with one idle cycle between
        run_conv("b2b0", 10'h0F0, 1'b0, 1'b1);
        run_conv("b2b1", 10'h30F, 1'b0, 1'b1);
        start = 1'b0;
        idle_cycles("b2b_end", 2, 10'h30F);

        // randomized codes
        for (int r = 0; r < 6; r++) begin
            rc = W'($urandom_range(0, (1 << W) - 1));
            run_conv($sformatf("rnd%0d", r), rc, 1'(($urandom_range(0, 1))), 1'b0);
            idle_cycles($sformatf("rnd%0d_gap", r), $urandom_range(1, 3), rc);
        end

        // reset mid-CONVERT: everything clears asynchronously
        prev = rc;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            cmp = 1'(($urandom_range(0, 1)));
            tick();
        end
        chk("pre_rst.result", 32'(result), 32'(prev));
        #2;
        rst = 1'b1;
        #1;
        chk("arst.result", 32'(result), 32'd0);
        chk("arst.dac", 32'(dac), 32'd0);
        chk("arst.sample", 32'(sample), 32'd0);
        chk("arst.eoc", 32'(eoc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        idle_cycles("post_rst", 5, 10'h000);
        run_conv("post_rst_conv", 10'h1C3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
